// File: rtl/btn_rpt_pkg.sv
// Shared constants and types for the button-report event encoder.
// Holds the case bit, default character map and the F4 report command framing.
package btn_rpt_pkg;

    localparam logic [7:0]   CASE_BIT     = 8'h20;
    // "TSBARLUD" in the low 64 bits: byte 0 = 'D', byte 7 = 'T'; buttons 8..15 default to NUL.
    localparam logic [127:0] DEF_CHAR_MAP = {64'h0, 64'h5453_4241_524C_5544};
    localparam logic [7:0]   F4_CMD       = 8'hF4;
    localparam int           F4_LEN       = 4;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_e;

endpackage

// File: rtl/btn_evt_fifo.sv
// Byte-wide synchronous FIFO with registered full/empty flags.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module btn_evt_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data_i,
    input  logic       wr_en_i,
    output logic [7:0] rd_data_o,
    input  logic       rd_en_i,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        do_wr, do_rd;

    assign do_rd = rd_en_i && !empty_q;
    assign do_wr = wr_en_i && (!full_q || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(do_rd);
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/btn_rpt_uart.sv
// Turns button state/change reports into one ASCII byte per changed button,
// buffered through a FIFO into a one-entry valid/ack output register.
module btn_rpt_uart
    import btn_rpt_pkg::*;
#(
    parameter int                 N_BTN      = 8,
    parameter logic [N_BTN-1:0]   BTN_MASK   = '1,
    parameter logic [8*N_BTN-1:0] CHAR_MAP   = DEF_CHAR_MAP[8*N_BTN-1:0],
    parameter int                 FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] rpt_state,
    input  logic [N_BTN-1:0] rpt_change,
    input  logic             rpt_stb,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [7:0]       ovf_cnt,
    input  logic             ovf_clr
);
    scan_state_e      state_q, state_d;
    logic [N_BTN-1:0] pend_chg_q, pend_chg_d;
    logic [N_BTN-1:0] pend_st_q, pend_st_d;
    logic [N_BTN-1:0] sel_onehot;
    logic [7:0]       evt_byte;
    logic             scan_en;
    logic             fifo_full, fifo_empty, fifo_pop, evt_drop;
    logic [7:0]       fifo_rd_data;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       ovf_cnt_q, ovf_cnt_d;

    // Lowest set pending bit wins; its byte is lowercased when the button was released.
    always_comb begin
        sel_onehot = '0;
        evt_byte   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_chg_q[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                evt_byte      = pend_st_q[i] ? CHAR_MAP[8*i +: 8] : (CHAR_MAP[8*i +: 8] | CASE_BIT);
            end
        end
    end

    always_comb begin
        scan_en = 1'b0;
        case (state_q)
            ST_IDLE: scan_en = (pend_chg_q != '0);
            ST_SCAN: scan_en = 1'b1;
            default: scan_en = 1'b0;
        endcase
        // A same-cycle strobe re-arms a bit the scanner is clearing.
        pend_chg_d = (pend_chg_q & ~(scan_en ? sel_onehot : '0))
                   | (rpt_stb ? (rpt_change & BTN_MASK) : '0);
        state_d    = (pend_chg_d != '0) ? ST_SCAN : ST_IDLE;
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_pend_st
        assign pend_st_d[gi] = (rpt_stb && rpt_change[gi]) ? rpt_state[gi] : pend_st_q[gi];
    end

    assign fifo_pop = !fifo_empty && (!out_valid_q || out_ack);
    assign evt_drop = scan_en && fifo_full && !fifo_pop;

    btn_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_data_i (evt_byte),
        .wr_en_i   (scan_en),
        .rd_data_o (fifo_rd_data),
        .rd_en_i   (fifo_pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (fifo_pop) begin
            out_data_d  = fifo_rd_data;
            out_valid_d = 1'b1;
        end else if (out_ack) begin
            out_valid_d = 1'b0;
        end

        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = evt_drop ? 8'd1 : 8'd0;
        end else if (evt_drop && ovf_cnt_q != 8'hFF) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_chg_q  <= '0;
            pend_st_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_chg_q  <= pend_chg_d;
            pend_st_q   <= pend_st_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
